// File: rtl/ram_arb_pkg.sv
// Shared defaults, requester-count limits and per-requester read tag encoding
// for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned NREQ_MIN = 2;
  localparam int unsigned NREQ_MAX = 8;
  localparam int unsigned AW_DEF   = 6;
  localparam int unsigned DW_DEF   = 8;

  // Which RAM port an outstanding read was issued on
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_P1   = 2'd1,
    TAG_P2   = 2'd2
  } port_tag_e;

endpackage

// File: rtl/ram_port_arbiter_rr_pick2.sv
// Round-robin two-winner picker: first requester at/after ptr, then the next
// requester that does not clash with the first (conf[first][cand]).
module rr_pick2
  import ram_arb_pkg::*;
#(
  parameter  int unsigned NREQ = NREQ_DEF,
  localparam int unsigned PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0][NREQ-1:0] conf,
  input  logic [PW-1:0]             ptr,
  output logic [PW-1:0]             idx1,
  output logic                      vld1,
  output logic [PW-1:0]             idx2,
  output logic                      vld2
);

  logic [PW-1:0] cand;

  always_comb begin
    idx1 = '0;
    vld1 = 1'b0;
    idx2 = '0;
    vld2 = 1'b0;
    cand = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = PW'((32'(ptr) + k) % NREQ);
      if (req[cand]) begin
        if (!vld1) begin
          idx1 = cand;
          vld1 = 1'b1;
        end else if (!vld2 && !conf[idx1][cand]) begin
          idx2 = cand;
          vld2 = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates NREQ requesters onto a dual-port RAM, two grants per cycle.
// Optional RAM_ARB_STATS_EN adds a saturating conflict_cnt output.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned DW   = DW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_adr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [NREQ*DW-1:0] rdata,
  output logic [DW-1:0]     data1,
  output logic [AW-1:0]     adr1,
  output logic              we1,
  output logic [DW-1:0]     data2,
  output logic [AW-1:0]     adr2,
  output logic              we2,
  input  logic [DW-1:0]     q1,
  input  logic [DW-1:0]     q2
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);

  localparam int unsigned PW = $clog2(NREQ);

  logic [AW-1:0]             adr_a [NREQ];
  logic [DW-1:0]             wd_a  [NREQ];
  logic [NREQ-1:0][NREQ-1:0] conf;
  logic [PW-1:0]             rr_ptr, i1, i2, last;
  logic                      v1_raw, v2_raw, v1, v2;
  port_tag_e                 tag [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign adr_a[g] = req_adr[g*AW +: AW];
    assign wd_a[g]  = req_wdata[g*DW +: DW];
    for (genvar h = 0; h < NREQ; h++) begin : g_conf
      assign conf[g][h] = (g != h) && (adr_a[g] == adr_a[h]) && (req_we[g] || req_we[h]);
    end
  end

  rr_pick2 #(
    .NREQ (NREQ)
  ) u_pick (
    .req  (req),
    .conf (conf),
    .ptr  (rr_ptr),
    .idx1 (i1),
    .vld1 (v1_raw),
    .idx2 (i2),
    .vld2 (v2_raw)
  );

  // Grants are blanked combinationally so nothing reaches the RAM during reset
  assign v1   = v1_raw & rst_n;
  assign v2   = v2_raw & rst_n;
  assign last = v2 ? i2 : i1;

  always_comb begin
    gnt   = '0;
    we1   = 1'b0;
    adr1  = '0;
    data1 = '0;
    we2   = 1'b0;
    adr2  = '0;
    data2 = '0;
    if (v1) begin
      gnt[i1] = 1'b1;
      we1     = req_we[i1];
      adr1    = adr_a[i1];
      data1   = wd_a[i1];
    end
    if (v2) begin
      gnt[i2] = 1'b1;
      we2     = req_we[i2];
      adr2    = adr_a[i2];
      data2   = wd_a[i2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (v1) begin
      rr_ptr <= (32'(last) == NREQ - 1) ? '0 : last + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREQ; i++) tag[i] <= TAG_NONE;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (v1 && 32'(i1) == i && !req_we[i])      tag[i] <= TAG_P1;
        else if (v2 && 32'(i2) == i && !req_we[i]) tag[i] <= TAG_P2;
        else                                       tag[i] <= TAG_NONE;
      end
    end
  end

  // RAM registers q one cycle after the address, aligning with the tag flop
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rvalid[i] = (tag[i] != TAG_NONE);
      case (tag[i])
        TAG_P1:  rdata[i*DW +: DW] = q1;
        TAG_P2:  rdata[i*DW +: DW] = q2;
        default: rdata[i*DW +: DW] = '0;
      endcase
    end
  end

`ifdef RAM_ARB_STATS_EN
  logic deferred;

  assign deferred = v1 && |(req & conf[i1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (deferred && conflict_cnt != '1) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule
